// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx: parallel config word -> MSB-first o_sclk/o_sdin frame.
// Build option: define SERIAL_CFG_PARITY_EN to append an even-parity bit.
// Ports: i_clk, i_resetbAll (async, active low),
//   i_cfg_data/i_cfg_valid/o_cfg_ready (word handshake),
//   o_sclk/o_sdin (serial pair), o_busy, o_done (1-cycle pulse),
//   o_frame_count (completed frames, wraps).
module serial_cfg_tx #(
  parameter int FRAME_BITS = 5,
  parameter int CLK_HALF   = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_resetbAll,
  input  logic [FRAME_BITS-1:0] i_cfg_data,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  output logic                  o_sclk,
  output logic                  o_sdin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_frame_count
);

`ifdef SERIAL_CFG_PARITY_EN
  localparam int NBITS = FRAME_BITS + 1;
`else
  localparam int NBITS = FRAME_BITS;
`endif
  localparam int PH_W = $clog2(CLK_HALF + 1);
  localparam int BC_W = $clog2(NBITS + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_HALF - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE, SHIFT_LO, SHIFT_HI, DONE
  } state_t;

  state_t r_state, w_state_nx;

  logic [NBITS-1:0] r_shift, w_shift_nx;
  logic [BC_W-1:0]  r_bitcnt, w_bitcnt_nx;
  logic [PH_W-1:0]  r_phase, w_phase_nx;
  logic             r_ready, w_ready_nx;
  logic             r_sclk, w_sclk_nx;
  logic             r_sdin, w_sdin_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;

  logic [NBITS-1:0] w_load;
  logic             w_ph_end;
  logic             w_last;

  // Parity (if enabled) rides along as the final shifted bit.
`ifdef SERIAL_CFG_PARITY_EN
  assign w_load = {i_cfg_data, ^i_cfg_data};
`else
  assign w_load = i_cfg_data;
`endif

  assign w_ph_end = (r_phase == PH_LAST);
  assign w_last   = (r_bitcnt == BC_LAST);

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_phase  <= '0;
      r_ready  <= 1'b1;
      r_sclk   <= 1'b0;
      r_sdin   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_shift  <= w_shift_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_phase  <= w_phase_nx;
      r_ready  <= w_ready_nx;
      r_sclk   <= w_sclk_nx;
      r_sdin   <= w_sdin_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:     if (i_cfg_valid) w_state_nx = SHIFT_LO;
      SHIFT_LO: if (w_ph_end) w_state_nx = SHIFT_HI;
      SHIFT_HI: if (w_ph_end) w_state_nx = w_last ? DONE : SHIFT_LO;
      DONE:     w_state_nx = IDLE;
      default:  w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_shift_nx  = r_shift;
    w_bitcnt_nx = r_bitcnt;
    w_phase_nx  = r_phase;
    w_ready_nx  = r_ready;
    w_sclk_nx   = r_sclk;
    w_sdin_nx   = r_sdin;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_cnt_nx    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_cfg_valid) begin
          w_shift_nx  = w_load;
          w_sdin_nx   = w_load[NBITS-1];
          w_ready_nx  = 1'b0;
          w_busy_nx   = 1'b1;
          w_bitcnt_nx = '0;
          w_phase_nx  = '0;
        end
      end
      SHIFT_LO: begin
        if (w_ph_end) begin
          w_sclk_nx  = 1'b1;
          w_phase_nx = '0;
        end else begin
          w_phase_nx = r_phase + PH_W'(1);
        end
      end
      SHIFT_HI: begin
        if (w_ph_end) begin
          // Data only moves on the falling sclk edge.
          w_sclk_nx  = 1'b0;
          w_phase_nx = '0;
          if (!w_last) begin
            w_shift_nx  = r_shift << 1;
            w_sdin_nx   = r_shift[NBITS-2];
            w_bitcnt_nx = r_bitcnt + BC_W'(1);
          end else begin
            w_sdin_nx = 1'b0;
            w_done_nx = 1'b1;
            w_cnt_nx  = r_cnt + CNT_W'(1);
          end
        end else begin
          w_phase_nx = r_phase + PH_W'(1);
        end
      end
      DONE: begin
        w_busy_nx  = 1'b0;
        w_ready_nx = 1'b1;
      end
      default: begin
        w_ready_nx = 1'b1;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign o_cfg_ready   = r_ready;
  assign o_sclk        = r_sclk;
  assign o_sdin        = r_sdin;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_frame_count = r_cnt;

endmodule

// File: tb/tb_serial_cfg_tx.sv
// tb_serial_cfg_tx: scoreboard bench for serial_cfg_tx.
// Driver queues expected frames on accept; monitor decodes o_sclk/o_sdin.
module tb_serial_cfg_tx;

  localparam int FB = 5;
  localparam int CH = 2;
  localparam int CW = 8;
`ifdef SERIAL_CFG_PARITY_EN
  localparam int NB = FB + 1;
`else
  localparam int NB = FB;
`endif

  logic          i_clk = 0;
  logic          rst_n = 0;
  logic [FB-1:0] i_cfg_data = '0;
  logic          i_cfg_valid = 0;
  logic          o_cfg_ready, o_sclk, o_sdin, o_busy, o_done;
  logic [CW-1:0] o_frame_count;

  serial_cfg_tx #(
    .FRAME_BITS(FB), .CLK_HALF(CH), .CNT_W(CW)
  ) dut (
    .i_clk(i_clk),
    .i_resetbAll(rst_n),
    .i_cfg_data(i_cfg_data),
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .o_sclk(o_sclk),
    .o_sdin(o_sdin),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_frame_count(o_frame_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [FB-1:0] d;
    int            e0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_cnt = 0;
  int   last_e0 = 0;
  bit   acc_f;

  int            rx_n = 0;
  logic [NB-1:0] rx_word = '0;
  logic          prev_sclk = 0;
  logic          prev_sdin = 0;
  bit            post_done = 0;

  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Bit k of a frame: payload MSB first, then even parity if enabled.
  function automatic logic exp_bit(input logic [FB-1:0] d, input int k);
    if (k < FB) return d[FB-1-k];
    return ^d;
  endfunction

  // Inputs change on negedge; an accept happens on the next posedge.
  task automatic step(input logic v, input logic [FB-1:0] d);
    exp_t e;
    @(negedge i_clk);
    i_cfg_valid = v;
    i_cfg_data  = d;
    acc_f = 0;
    if (v && o_cfg_ready && rst_n) begin
      e.d  = d;
      e.e0 = cyc + 1;
      q.push_back(e);
      last_e0 = cyc + 1;
      acc_f = 1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || o_busy || post_done) && n < 300) begin
      step(0, FB'($urandom));
      n = n + 1;
    end
    chk("idle_timeout", q.size(), 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ready"}, o_cfg_ready, 1);
    chk({nm, "_sclk"}, o_sclk, 0);
    chk({nm, "_sdin"}, o_sdin, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_count"}, o_frame_count, 0);
  endtask

  initial forever begin
    exp_t e;
    @(negedge i_clk);
    if (!rst_n) begin
      prev_sclk = 0;
      prev_sdin = 0;
      rx_n = 0;
      post_done = 0;
    end else begin
      if (post_done) begin
        chk("ready_after_done", o_cfg_ready, 1);
        chk("busy_after_done", o_busy, 0);
        chk("done_width", o_done, 0);
        post_done = 0;
      end
      if (o_sclk && !prev_sclk) begin
        if (q.size() == 0) begin
          chk("spurious_sclk", 1, 0);
        end else begin
          chk("rise_time", cyc - q[0].e0, (2 * rx_n + 1) * CH);
          chk("bit", o_sdin, exp_bit(q[0].d, rx_n));
          chk("busy_in_frame", o_busy, 1);
        end
        rx_word = {rx_word[NB-2:0], o_sdin};
        rx_n = rx_n + 1;
      end
      if (o_sclk && prev_sclk)
        chk("sdin_stable", o_sdin, prev_sdin);
      if (o_done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          logic [FB-1:0] pay;
          e = q.pop_front();
          model_cnt = (model_cnt + 1) % (1 << CW);
          pay = FB'(rx_word >> (NB - FB));
          chk("done_time", cyc - e.e0, 2 * CH * NB);
          chk("bit_count", rx_n, NB);
          chk("frame_data", pay, e.d);
          chk("gain", pay[2:0], e.d[2:0]);
          chk("frame_count", o_frame_count, model_cnt);
          chk("sdin_at_done", o_sdin, 0);
          chk("sclk_at_done", o_sclk, 0);
        end
        rx_n = 0;
        post_done = 1;
      end
      prev_sclk = o_sclk;
      prev_sdin = o_sdin;
    end
  end

  initial begin
    int e1, acc, n;
    repeat (3) @(posedge i_clk);
    #2 rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      step(0, 5'b10101);
      chk_reset_outs("idle");
    end

    step(1, 5'b10110);
    step(0, 5'b01001);
    wait_idle();

    step(1, 5'b00111);
    e1 = last_e0;
    acc = 0;
    n = 0;
    while (acc == 0 && n < 60) begin
      step(1, 5'b11000);
      acc = int'(acc_f);
      n = n + 1;
    end
    chk("b2b_gap", last_e0 - e1, 2 * CH * NB + 2);
    step(0, 5'b11111);
    wait_idle();

    step(1, 5'b11011);
    while (cyc < last_e0 + 8) step(0, FB'($urandom));
    @(posedge i_clk);
    #2 rst_n = 0;
    #1 chk_reset_outs("midreset");
    q.delete();
    model_cnt = 0;
    repeat (2) @(posedge i_clk);
    #2 chk_reset_outs("inreset");
    rst_n = 1;
    step(1, 5'b00001);
    step(0, 5'b11110);
    wait_idle();
    chk("count_after_reset", o_frame_count, 1);

    acc = 0;
    for (int c = 0; c < 20000 && acc < 300; c++) begin
      step($urandom_range(0, 2) != 0, FB'($urandom));
      if (acc_f) acc = acc + 1;
    end
    chk("rand_accepts", acc, 300);
    step(0, 5'b0);
    wait_idle();
    chk("final_count", o_frame_count, model_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
